pc_sequencer: RTL and testbench

Program-counter sequencer for the fetch stage: holds the 64-bit PC, requests instructions from instruction memory over a req/ready handshake, and consumes the branch target produced by the branch-target adder. It advances by 4, redirects on taken branches, squashes wrong-path fetches, honours pipeline stalls, and traps on misaligned targets. Sits between the branch-target adder / control unit and the instruction memory port.

---
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer for the fetch stage. Holds the PC, issues
// instruction-memory requests over a req/ready handshake, follows taken
// branches (squashing the wrong-path fetch that is in flight) and traps
// permanently on a misaligned branch target until the next reset.
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_rst_n          synchronous active-low reset
//   i_branch_taken   redirect request from control, one-cycle pulse
//   i_branch_target  redirect address from the branch-target adder
//   i_stall          pipeline stall, honoured at the next handshake
//   i_imem_ready     memory accepts/returns the current request
//   o_imem_req       fetch request
//   o_imem_addr      fetch address (always equal to o_pc)
//   o_pc             current PC
//   o_pc_plus4       o_pc + 4, modulo 2^64
//   o_inst_valid     instruction returned this cycle is on the correct path
//   o_misalign_err   sticky misaligned-target flag
//   o_squash_count   saturating count of squashed fetches
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_branch_taken,
  input  logic [63:0]      i_branch_target,
  input  logic             i_stall,
  input  logic             i_imem_ready,
  output logic             o_imem_req,
  output logic [63:0]      o_imem_addr,
  output logic [63:0]      o_pc,
  output logic [63:0]      o_pc_plus4,
  output logic             o_inst_valid,
  output logic             o_misalign_err,
  output logic [CNT_W-1:0] o_squash_count
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_TRAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [63:0]      r_pc;
  logic [63:0]      r_pend_tgt;
  logic             r_pend_vld;
  logic             r_trap_pend;
  logic             r_misalign;
  logic [CNT_W-1:0] r_squash;

  logic        w_fetch;
  logic        w_hs;
  logic        w_br_bad;
  logic        w_squash;
  logic        w_trap_now;
  logic [63:0] w_pc_plus4;

  assign w_fetch    = (r_state == S_FETCH);
  assign w_hs       = w_fetch & i_imem_ready;
  assign w_br_bad   = i_branch_taken & (i_branch_target[1:0] != 2'b00);
  // r_pend_vld also covers a latched misaligned redirect, so the squash at
  // handshake is counted for both kinds of pending redirect.
  assign w_squash   = w_hs & (i_branch_taken | r_pend_vld);
  // A misaligned redirect seen while waiting is committed: later branches
  // before the handshake cannot cancel the trap.
  assign w_trap_now = w_hs & (r_trap_pend | w_br_bad);
  assign w_pc_plus4 = r_pc + 64'd4;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_br_bad)     w_state_nxt = S_TRAP;
        else if (i_stall) w_state_nxt = S_HOLD;
        else              w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_hs) begin
          if (w_trap_now)   w_state_nxt = S_TRAP;
          else if (i_stall) w_state_nxt = S_HOLD;
          else              w_state_nxt = S_FETCH;
        end
      end
      S_HOLD: begin
        if (w_br_bad)      w_state_nxt = S_TRAP;
        else if (!i_stall) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_TRAP;
    endcase
  end

  // Outputs
  always_comb begin
    o_imem_req   = w_fetch;
    o_inst_valid = w_fetch & i_imem_ready & ~i_branch_taken & ~r_pend_vld;
  end

  assign o_imem_addr    = r_pc;
  assign o_pc           = r_pc;
  assign o_pc_plus4     = w_pc_plus4;
  assign o_misalign_err = r_misalign;
  assign o_squash_count = r_squash;

  // PC, pending redirect, error flag and squash counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc        <= RESET_PC;
      r_pend_vld  <= 1'b0;
      r_trap_pend <= 1'b0;
      r_misalign  <= 1'b0;
      r_squash    <= '0;
    end else begin
      if (w_br_bad && (r_state != S_TRAP)) r_misalign <= 1'b1;
      if (w_squash && !(&r_squash)) r_squash <= r_squash + 1'b1;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (i_branch_taken && !w_br_bad) r_pc <= i_branch_target;
        end
        S_FETCH: begin
          if (w_hs) begin
            r_pend_vld  <= 1'b0;
            r_trap_pend <= 1'b0;
            if (!w_trap_now) begin
              if (i_branch_taken)  r_pc <= i_branch_target;
              else if (r_pend_vld) r_pc <= r_pend_tgt;
              else                 r_pc <= w_pc_plus4;
            end
          end else if (i_branch_taken && !r_trap_pend) begin
            r_pend_vld <= 1'b1;
            if (w_br_bad) r_trap_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pending target is pure data; it is only consumed while r_pend_vld is set.
  always_ff @(posedge i_clk) begin
    if (w_fetch && !w_hs && i_branch_taken && !w_br_bad && !r_trap_pend)
      r_pend_tgt <= i_branch_target;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int          CNT_W = 2;
  localparam logic [63:0] RST_PC = 64'h1000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             branch_taken;
  logic [63:0]      branch_target;
  logic             stall;
  logic             imem_ready;
  logic             imem_req;
  logic [63:0]      imem_addr;
  logic [63:0]      pc;
  logic [63:0]      pc_plus4;
  logic             inst_valid;
  logic             misalign_err;
  logic [CNT_W-1:0] squash_count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic        req;
    logic [63:0] pc;
    logic        iv;
    logic [1:0]  sq;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_stall         (stall),
    .i_imem_ready    (imem_ready),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .o_pc            (pc),
    .o_pc_plus4      (pc_plus4),
    .o_inst_valid    (inst_valid),
    .o_misalign_err  (misalign_err),
    .o_squash_count  (squash_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what,
                     input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s %s: observed %h expected %h", tag, what, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "imem_req",     {63'd0, imem_req},        {63'd0, e.req});
    chk(e.tag, "imem_addr",    imem_addr,                e.pc);
    chk(e.tag, "pc",           pc,                       e.pc);
    chk(e.tag, "pc_plus4",     pc_plus4,                 e.pc + 64'd4);
    chk(e.tag, "inst_valid",   {63'd0, inst_valid},      {63'd0, e.iv});
    chk(e.tag, "squash_count", {62'd0, squash_count},    {62'd0, e.sq});
    chk(e.tag, "misalign_err", {63'd0, misalign_err},    {63'd0, e.mis});
  endtask

  // One clock cycle: drive inputs after the falling edge, push the outputs
  // expected for this cycle, then compare them before the next rising edge.
  task automatic cyc(input string tag, input logic rst_i, input logic br,
                     input logic [63:0] tgt, input logic stl, input logic rdy,
                     input logic e_req, input logic [63:0] e_pc, input logic e_iv,
                     input logic [1:0] e_sq, input logic e_mis);
    exp_t e;
    @(negedge clk);
    rst_n         = rst_i;
    branch_taken  = br;
    branch_target = tgt;
    stall         = stl;
    imem_ready    = rdy;
    e.tag = tag; e.req = e_req; e.pc = e_pc; e.iv = e_iv; e.sq = e_sq; e.mis = e_mis;
    sb.push_back(e);
    #2;
    check_out();
  endtask

  initial begin
    rst_n         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    stall         = 1'b0;
    imem_ready    = 1'b0;
    repeat (2) @(posedge clk);

    //   tag     rst br tgt                    stl rdy req pc                     iv sq mis
    cyc("rst0",  0,  0, 64'h0,                 0,  0,  0,  64'h1000,              0, 0, 0);
    cyc("idle0", 1,  0, 64'h0,                 0,  0,  0,  64'h1000,              0, 0, 0);
    cyc("seq0",  1,  0, 64'h0,                 0,  1,  1,  64'h1000,              1, 0, 0);
    cyc("seq1",  1,  0, 64'h0,                 0,  1,  1,  64'h1004,              1, 0, 0);
    cyc("seq2",  1,  0, 64'h0,                 0,  1,  1,  64'h1008,              1, 0, 0);
    // reset asserted while a request is outstanding
    cyc("rstmid",0,  0, 64'h0,                 0,  1,  1,  64'h100C,              1, 0, 0);
    cyc("rst1",  0,  0, 64'h0,                 0,  0,  0,  64'h1000,              0, 0, 0);
    cyc("idle1", 1,  0, 64'h0,                 0,  0,  0,  64'h1000,              0, 0, 0);
    cyc("f1000", 1,  0, 64'h0,                 0,  1,  1,  64'h1000,              1, 0, 0);
    // wait states with a redirect arriving mid-wait
    cyc("wait1", 1,  0, 64'h0,                 0,  0,  1,  64'h1004,              0, 0, 0);
    cyc("wait2", 1,  1, 64'h2000,              0,  0,  1,  64'h1004,              0, 0, 0);
    cyc("wait3", 1,  0, 64'h0,                 0,  0,  1,  64'h1004,              0, 0, 0);
    cyc("sqhs",  1,  0, 64'h0,                 0,  1,  1,  64'h1004,              0, 0, 0);
    cyc("f2000", 1,  0, 64'h0,                 0,  1,  1,  64'h2000,              1, 1, 0);
    // branch at handshake together with a two-cycle stall
    cyc("brstl", 1,  1, 64'h3000,              1,  1,  1,  64'h2004,              0, 1, 0);
    cyc("hold1", 1,  0, 64'h0,                 1,  1,  0,  64'h3000,              0, 2, 0);
    cyc("hold2", 1,  0, 64'h0,                 0,  1,  0,  64'h3000,              0, 2, 0);
    cyc("f3000", 1,  0, 64'h0,                 0,  1,  1,  64'h3000,              1, 2, 0);
    // stall raised during a wait only takes effect at the handshake
    cyc("stlw",  1,  0, 64'h0,                 1,  0,  1,  64'h3004,              0, 2, 0);
    cyc("stlhs", 1,  0, 64'h0,                 1,  1,  1,  64'h3004,              1, 2, 0);
    cyc("hold3", 1,  0, 64'h0,                 0,  1,  0,  64'h3008,              0, 2, 0);
    cyc("f3008", 1,  0, 64'h0,                 0,  1,  1,  64'h3008,              1, 2, 0);
    // redirect to the top of the address space, wrap, counter saturation
    cyc("brtop", 1,  1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1,  64'h300C,              0, 2, 0);
    cyc("top",   1,  0, 64'h0,                 0,  1,  1,  64'hFFFF_FFFF_FFFF_FFFC, 1, 3, 0);
    chk("top", "pc_plus4_wrap", pc_plus4, 64'h0);
    cyc("wrap0", 1,  1, 64'h40,                0,  1,  1,  64'h0,                 0, 3, 0);
    chk("wrap0", "pc_plus4_low", pc_plus4, 64'h4);
    cyc("sat",   1,  0, 64'h0,                 0,  1,  1,  64'h40,                1, 3, 0);
    // two redirects while waiting: the newest target wins
    cyc("pend1", 1,  1, 64'h100,               0,  0,  1,  64'h44,                0, 3, 0);
    cyc("pend2", 1,  1, 64'h200,               0,  0,  1,  64'h44,                0, 3, 0);
    cyc("pendhs",1,  0, 64'h0,                 0,  1,  1,  64'h44,                0, 3, 0);
    cyc("f200",  1,  0, 64'h0,                 0,  1,  1,  64'h200,               1, 3, 0);
    // branch while in HOLD loads the PC directly
    cyc("toHold",1,  0, 64'h0,                 1,  1,  1,  64'h204,               1, 3, 0);
    cyc("hbr",   1,  1, 64'h500,               1,  1,  0,  64'h208,               0, 3, 0);
    cyc("hold4", 1,  0, 64'h0,                 0,  1,  0,  64'h500,               0, 3, 0);
    cyc("f500",  1,  0, 64'h0,                 0,  1,  1,  64'h500,               1, 3, 0);
    // misaligned target at handshake -> permanent trap
    cyc("mis",   1,  1, 64'h2002,              0,  1,  1,  64'h504,               0, 3, 0);
    cyc("trap1", 1,  0, 64'h0,                 0,  1,  0,  64'h504,               0, 3, 1);
    cyc("trap2", 1,  1, 64'h600,               0,  1,  0,  64'h504,               0, 3, 1);
    cyc("trap3", 0,  0, 64'h0,                 0,  1,  0,  64'h504,               0, 3, 1);
    cyc("rst2",  0,  0, 64'h0,                 0,  0,  0,  64'h1000,              0, 0, 0);
    cyc("idle2", 1,  0, 64'h0,                 0,  0,  0,  64'h1000,              0, 0, 0);
    // misaligned redirect while waiting: request completes squashed, then trap
    cyc("misw",  1,  1, 64'h7001,              0,  0,  1,  64'h1000,              0, 0, 0);
    cyc("misw2", 1,  1, 64'h8000,              0,  0,  1,  64'h1000,              0, 0, 1);
    cyc("mishs", 1,  0, 64'h0,                 0,  1,  1,  64'h1000,              0, 0, 1);
    cyc("trap4", 1,  0, 64'h0,                 0,  1,  0,  64'h1000,              0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
